// File: rtl/msx_opl4_busif.sv
// msx_opl4_busif: decodes a Z80 I/O port window and sequences YMF278B chip strobes.
// Latency: 2-clock input sync, then ACC_CYCLES of chip strobe; a recovery count spaces accesses.
// Backpressure: msx_WAIT_n stalls the Z80 from decode until the access reaches DONE.
module msx_opl4_busif #(
  parameter logic [7:0] BASE_PORT   = 8'h7E,
  parameter int         ADDR_BITS   = 1,
  parameter int         ACC_CYCLES  = 2,
  parameter int         WR_RECOVERY = 8,
  parameter int         RD_RECOVERY = 2
) (
  input  logic       msx_CLK,
  input  logic       msx_RESET_n,
  input  logic [7:0] msx_A,
  input  logic       msx_IORQ_n,
  input  logic       msx_M1_n,
  input  logic       msx_RD_n,
  input  logic       msx_WR_n,
  output logic       y_CS_n,
  output logic [2:0] y_A,
  output logic       y_RD_n,
  output logic       y_WR_n,
  output logic       msx_WAIT_n,
  output logic       msx_busdir,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, WAITREC, ACCESS, DONE} state_t;

  localparam logic [2:0] A_MASK   = 3'((1 << ADDR_BITS) - 1);
  localparam logic [3:0] ACC_LOAD = 4'(ACC_CYCLES - 1);
  localparam logic [7:0] WR_REC   = 8'(WR_RECOVERY);
  localparam logic [7:0] RD_REC   = 8'(RD_RECOVERY);

  state_t     state, state_nxt;
  logic [1:0] hit_q, rd_n_q, wr_n_q;
  logic [3:0] acc_cnt;
  logic [7:0] rec_cnt, rec_nxt;
  logic       is_wr_q, is_wr_nxt;
  logic       latch, rec_load;
  logic       raw_hit, hit_s, rd_s, wr_s, acc_req;
  logic       in_strobe_nxt, rd_phase_nxt;

  // Raw decode: I/O cycle (not interrupt acknowledge) inside the port window.
  assign raw_hit = !msx_IORQ_n && msx_M1_n &&
                   (msx_A[7:ADDR_BITS] == BASE_PORT[7:ADDR_BITS]);

  assign hit_s   = hit_q[1];
  assign rd_s    = !rd_n_q[1];
  assign wr_s    = !wr_n_q[1];
  // Exactly one strobe must be active; both-low or both-high is not an access.
  assign acc_req = hit_s && (rd_s ^ wr_s);

  // WAIT is held low from raw decode until DONE so the CPU cycle spans the chip access.
  assign msx_WAIT_n = !(msx_RESET_n && raw_hit && (!msx_RD_n || !msx_WR_n) && (state != DONE));

  // Two-stage synchronisers for the decoded hit and the CPU strobes.
  always_ff @(posedge msx_CLK) begin
    if (!msx_RESET_n) begin
      hit_q  <= 2'b00;
      rd_n_q <= 2'b11;
      wr_n_q <= 2'b11;
    end else begin
      hit_q  <= {hit_q[0], raw_hit};
      rd_n_q <= {rd_n_q[0], msx_RD_n};
      wr_n_q <= {wr_n_q[0], msx_WR_n};
    end
  end

  // State register.
  always_ff @(posedge msx_CLK) begin
    if (!msx_RESET_n) state <= IDLE;
    else              state <= state_nxt;
  end

  // Next-state logic, access latch and recovery reload decisions.
  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    rec_load  = 1'b0;
    case (state)
      IDLE: begin
        if (acc_req) begin
          if (rec_cnt == 8'd0) begin
            state_nxt = ACCESS;
            latch     = 1'b1;
          end else begin
            state_nxt = WAITREC;
          end
        end
      end
      WAITREC: begin
        if (!acc_req) begin
          state_nxt = IDLE;
        end else if (rec_cnt == 8'd0) begin
          state_nxt = ACCESS;
          latch     = 1'b1;
        end
      end
      ACCESS: begin
        // Runs its full length even if the CPU strobe is already gone.
        if (acc_cnt == 4'd0) state_nxt = DONE;
      end
      DONE: begin
        if (is_wr_q ? !wr_s : !rd_s) begin
          state_nxt = IDLE;
          rec_load  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    is_wr_nxt     = latch ? wr_s : is_wr_q;
    in_strobe_nxt = (state_nxt == ACCESS);
    // Reads keep the chip selected through DONE so data stays on the bus until the CPU lets go.
    rd_phase_nxt  = ((state_nxt == ACCESS) || (state_nxt == DONE)) && !is_wr_nxt;

    if (rec_load)               rec_nxt = is_wr_q ? WR_REC : RD_REC;
    else if (rec_cnt != 8'd0)   rec_nxt = rec_cnt - 8'd1;
    else                        rec_nxt = 8'd0;
  end

  // Datapath and registered outputs, computed from the next state so they align with it.
  always_ff @(posedge msx_CLK) begin
    if (!msx_RESET_n) begin
      acc_cnt    <= 4'd0;
      rec_cnt    <= 8'd0;
      is_wr_q    <= 1'b0;
      y_A        <= 3'd0;
      y_CS_n     <= 1'b1;
      y_RD_n     <= 1'b1;
      y_WR_n     <= 1'b1;
      msx_busdir <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (latch) begin
        acc_cnt <= ACC_LOAD;
        y_A     <= msx_A[2:0] & A_MASK;
      end else if ((state == ACCESS) && (acc_cnt != 4'd0)) begin
        acc_cnt <= acc_cnt - 4'd1;
      end
      is_wr_q    <= is_wr_nxt;
      rec_cnt    <= rec_nxt;
      busy       <= (rec_nxt != 8'd0);
      y_CS_n     <= !(in_strobe_nxt || rd_phase_nxt);
      y_RD_n     <= !rd_phase_nxt;
      y_WR_n     <= !(in_strobe_nxt && is_wr_nxt);
      msx_busdir <= !rd_phase_nxt;
    end
  end

endmodule

// File: tb/tb_msx_opl4_busif.sv
// tb_msx_opl4_busif: directed checks of three msx_opl4_busif configurations on a shared bus.
// Instance 0 uses defaults, instance 1 a wide window at C0h, instance 2 a 4-clock strobe.
// Outputs are sampled on the falling clock edge; inputs change on the falling edge.
module tb_msx_opl4_busif;

  logic       clk;
  logic       rst_n;
  logic [7:0] a;
  logic       iorq_n, m1_n, rd_n, wr_n;

  wire [2:0] ycs, yrd, ywr, wt, bd, bz;
  wire [2:0] ya [3];

  int ncmp = 0;
  int nerr = 0;

  int cyc = 0;
  int wr_lo[3], rd_lo[3], cs_lo[3], bd_lo[3], busy_hi[3], nstart[3], wr_start[3], busy_fall[3];
  logic [2:0] ya_cap [3];
  logic [2:0] pwr = 3'b111;
  logic [2:0] pbz = 3'b000;

  typedef struct {
    logic [7:0] a;
    logic       iorq_n, m1_n, rd_n, wr_n;
    logic       w0, w1;
  } vec_t;
  vec_t tbl[10];

  msx_opl4_busif u0 (
    .msx_CLK(clk), .msx_RESET_n(rst_n), .msx_A(a), .msx_IORQ_n(iorq_n), .msx_M1_n(m1_n),
    .msx_RD_n(rd_n), .msx_WR_n(wr_n), .y_CS_n(ycs[0]), .y_A(ya[0]), .y_RD_n(yrd[0]),
    .y_WR_n(ywr[0]), .msx_WAIT_n(wt[0]), .msx_busdir(bd[0]), .busy(bz[0]));

  msx_opl4_busif #(.BASE_PORT(8'hC0), .ADDR_BITS(3)) u1 (
    .msx_CLK(clk), .msx_RESET_n(rst_n), .msx_A(a), .msx_IORQ_n(iorq_n), .msx_M1_n(m1_n),
    .msx_RD_n(rd_n), .msx_WR_n(wr_n), .y_CS_n(ycs[1]), .y_A(ya[1]), .y_RD_n(yrd[1]),
    .y_WR_n(ywr[1]), .msx_WAIT_n(wt[1]), .msx_busdir(bd[1]), .busy(bz[1]));

  msx_opl4_busif #(.ACC_CYCLES(4)) u2 (
    .msx_CLK(clk), .msx_RESET_n(rst_n), .msx_A(a), .msx_IORQ_n(iorq_n), .msx_M1_n(m1_n),
    .msx_RD_n(rd_n), .msx_WR_n(wr_n), .y_CS_n(ycs[2]), .y_A(ya[2]), .y_RD_n(yrd[2]),
    .y_WR_n(ywr[2]), .msx_WAIT_n(wt[2]), .msx_busdir(bd[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-cycle activity counters for each instance.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      if (ywr[i] == 1'b0) wr_lo[i]++;
      if (yrd[i] == 1'b0) rd_lo[i]++;
      if (ycs[i] == 1'b0) cs_lo[i]++;
      if (bd[i] == 1'b0)  bd_lo[i]++;
      if (bz[i] == 1'b1)  busy_hi[i]++;
      if (ywr[i] == 1'b0 && pwr[i] == 1'b1) begin
        nstart[i]++;
        wr_start[i] = cyc;
        ya_cap[i]   = ya[i];
      end
      if (bz[i] == 1'b0 && pbz[i] == 1'b1) busy_fall[i] = cyc;
      pwr[i] = ywr[i];
      pbz[i] = bz[i];
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    for (int i = 0; i < 3; i++) begin
      wr_lo[i] = 0; rd_lo[i] = 0; cs_lo[i] = 0; bd_lo[i] = 0;
      busy_hi[i] = 0; nstart[i] = 0;
    end
  endtask

  task automatic bus_idle();
    a = 8'h00; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One Z80 I/O cycle: assert, hold while the selected instance asks for wait, hold extra, release.
  task automatic io(input logic [7:0] ad, input bit is_wr, input bit m1, input int sel,
                    input int extra, output int waits);
    bit got;
    got   = 1'b0;
    waits = 0;
    @(negedge clk);
    a = ad; iorq_n = 1'b0; m1_n = m1;
    if (is_wr) wr_n = 1'b0; else rd_n = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wt[sel] == 1'b1) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    chk("io_wait_bound", got, 1);
    repeat (extra) @(negedge clk);
    bus_idle();
  endtask

  initial begin
    int w, w2, n;
    bit got;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w, w2, n;
    bit got;

    tbl[0] = '{8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{8'h7C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{8'h7E, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{8'h7E, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{8'hC5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8] = '{8'hC8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{8'hC7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    bus_idle();
    settle(3);

    // Reset state of all three instances.
    chk("rst_y_CS_n", ycs, 7);
    chk("rst_y_RD_n", yrd, 7);
    chk("rst_y_WR_n", ywr, 7);
    chk("rst_busdir", bd, 7);
    chk("rst_busy", bz, 0);
    chk("rst_wait", wt, 7);
    for (int i = 0; i < 3; i++) chk("rst_y_A", ya[i], 0);
    // WAIT stays released during reset even with a decoded access on the bus.
    a = 8'h7E; iorq_n = 1'b0; wr_n = 1'b0;
    #1;
    chk("rst_wait_hit", wt[0], 1);
    bus_idle();
    @(negedge clk);
    rst_n = 1'b1;
    settle(3);

    // Combinational WAIT decode, applied and withdrawn between clock edges.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      a = tbl[i].a; iorq_n = tbl[i].iorq_n; m1_n = tbl[i].m1_n;
      rd_n = tbl[i].rd_n; wr_n = tbl[i].wr_n;
      #1;
      chk($sformatf("vec%0d_wait_u0", i), wt[0], tbl[i].w0);
      chk($sformatf("vec%0d_wait_u1", i), wt[1], tbl[i].w1);
      #1;
      bus_idle();
    end
    settle(3);

    // OUT 7Eh then OUT 7Fh back to back: second write held off by write recovery.
    clr();
    io(8'h7E, 1'b1, 1'b1, 0, 1, w);
    chk("b2b_first_waits", w, 3);
    chk("b2b_first_y_A", ya_cap[0], 0);
    chk("b2b_first_wr_clocks", wr_lo[0], 2);
    io(8'h7F, 1'b1, 1'b1, 0, 1, w2);
    chk("b2b_second_waits", w2, 11);
    chk("b2b_second_y_A", ya_cap[0], 1);
    chk("b2b_wr_clocks_total", wr_lo[0], 4);
    chk("b2b_wr_starts", nstart[0], 2);
    chk("b2b_start_after_busy", wr_start[0] - busy_fall[0], 1);
    settle(30);
    chk("b2b_busy_clocks", busy_hi[0], 16);
    chk("b2b_u1_untouched", wr_lo[1], 0);

    // IN 7Fh: chip select, read strobe and bus direction track the CPU read.
    clr();
    io(8'h7F, 1'b0, 1'b1, 0, 1, w);
    chk("rd_waits", w, 3);
    settle(30);
    chk("rd_rd_clocks", rd_lo[0], 6);
    chk("rd_cs_clocks", cs_lo[0], 6);
    chk("rd_busdir_clocks", bd_lo[0], 6);
    chk("rd_no_wr", wr_lo[0], 0);
    chk("rd_busy_clocks", busy_hi[0], 2);

    // Interrupt acknowledge and out-of-window ports.
    clr();
    io(8'h7E, 1'b1, 1'b0, 0, 6, w);
    chk("m1_waits", w, 0);
    io(8'h7C, 1'b1, 1'b1, 0, 6, w);
    chk("p7C_waits", w, 0);
    io(8'h80, 1'b0, 1'b1, 0, 6, w);
    chk("p80_waits", w, 0);
    settle(10);
    chk("miss_cs_u0", cs_lo[0], 0);
    chk("miss_cs_u1", cs_lo[1], 0);

    // Wide window at C0h.
    clr();
    io(8'hC5, 1'b1, 1'b1, 1, 1, w);
    chk("c5_waits", w, 3);
    settle(30);
    chk("c5_y_A", ya_cap[1], 5);
    chk("c5_wr_clocks", wr_lo[1], 2);
    chk("c5_u0_untouched", cs_lo[0], 0);
    clr();
    io(8'hC8, 1'b1, 1'b1, 1, 1, w);
    chk("c8_waits", w, 0);
    settle(10);
    chk("c8_no_cs", cs_lo[1], 0);

    // Strobe withdrawn after the first ACCESS clock: strobe still runs its full length.
    clr();
    @(negedge clk);
    a = 8'h7E; iorq_n = 1'b0; wr_n = 1'b0;
    settle(3);
    chk("short_in_access", ywr[2], 0);
    bus_idle();
    settle(30);
    chk("short_u2_wr_clocks", wr_lo[2], 4);
    chk("short_u2_busy", busy_hi[2], 8);
    chk("short_u0_wr_clocks", wr_lo[0], 2);
    chk("short_u0_busy", busy_hi[0], 8);

    // Reset in the middle of ACCESS with the strobe held through release.
    clr();
    @(negedge clk);
    a = 8'h7E; iorq_n = 1'b0; wr_n = 1'b0;
    settle(3);
    chk("mid_in_access", ywr[0], 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_y_CS_n", ycs, 7);
    chk("mid_rst_y_WR_n", ywr, 7);
    chk("mid_rst_y_RD_n", yrd, 7);
    chk("mid_rst_busdir", bd, 7);
    chk("mid_rst_busy", bz, 0);
    chk("mid_rst_y_A", ya[0], 0);
    chk("mid_rst_wait", wt[0], 1);
    rst_n = 1'b1;
    clr();
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wt[0] == 1'b1) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    chk("mid_wait_bound", got, 1);
    chk("mid_new_waits", n, 4);
    @(negedge clk);
    bus_idle();
    settle(30);
    chk("mid_new_starts", nstart[0], 1);
    chk("mid_new_wr_clocks", wr_lo[0], 2);
    chk("mid_new_busy", busy_hi[0], 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
